// File: rtl/sync_pulse_pkg.sv
// Shared edge-mode encodings and the per-channel edge qualifier
// for the multi-channel pulse synchronizer.
package sync_pulse_pkg;

    localparam logic [1:0] EDGE_ANY  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_OFF  = 2'b11;

    function automatic logic edge_hit(
        input logic [1:0] mode,
        input logic       cur,
        input logic       prv
    );
        logic hit;
        hit = 1'b0;
        unique case (mode)
            EDGE_ANY:  hit = cur ^ prv;
            EDGE_RISE: hit = cur & ~prv;
            EDGE_FALL: hit = ~cur & prv;
            EDGE_OFF:  hit = 1'b0;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/sync_pulse_chan.sv
// One channel: synchronizer chain, edge detect, sticky pending and
// overrun flags, saturating event counter.
module sync_pulse_chan
    import sync_pulse_pkg::*;
#(
    parameter int         SYNC_STAGE = 2,
    parameter int         CNT_W      = 8,
    parameter logic [1:0] MODE       = EDGE_ANY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_async_i,
    input  logic             warm_done_i,
    input  logic             clr_i,
    input  logic             ack_i,
    output logic             pulse_o,
    output logic             pend_o,
    output logic             overrun_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [SYNC_STAGE-1:0] sync_q;
    logic                  prev_q;
    logic                  pulse_q, pulse_d;
    logic                  pend_q, pend_d;
    logic                  ovr_q, ovr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  synced;
    logic                  evt;

    assign synced = sync_q[SYNC_STAGE-1];
    assign evt    = warm_done_i & edge_hit(MODE, synced, prev_q);

    always_comb begin
        pulse_d = evt;
        pend_d  = pend_q;
        ovr_d   = ovr_q;
        cnt_d   = cnt_q;
        // An event landing with the ack keeps the flag set.
        if (evt) begin
            pend_d = 1'b1;
        end else if (ack_i) begin
            pend_d = 1'b0;
        end
        if (clr_i) begin
            ovr_d = 1'b0;
        end else if (evt && pend_q && !ack_i) begin
            ovr_d = 1'b1;
        end
        if (clr_i) begin
            cnt_d = CNT_W'(evt);
        end else if (evt && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGE-2:0], sig_async_i};
            prev_q  <= synced;
            pulse_q <= pulse_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pulse_o   = pulse_q;
    assign pend_o    = pend_q;
    assign overrun_o = ovr_q;
    assign cnt_o     = cnt_q;

endmodule

// File: rtl/sync_pulse_multi_capture.sv
// Multi-channel receive-side pulse synchronizer: shared warmup
// counter plus CH independent channel slices.
module sync_pulse_multi_capture
    import sync_pulse_pkg::*;
#(
    parameter int              CH         = 4,
    parameter int              SYNC_STAGE = 2,
    parameter int              CNT_W      = 8,
    parameter logic [2*CH-1:0] EDGE_MODE  = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH-1:0]       sig_async,
    input  logic [CH-1:0]       ack,
    input  logic                clr,
    output logic [CH-1:0]       pulse_out,
    output logic [CH-1:0]       pend,
    output logic [CH-1:0]       overrun,
    output logic [CH*CNT_W-1:0] evt_cnt
);

    localparam int         WW       = $clog2(SYNC_STAGE + 2);
    localparam logic [WW-1:0] WARM_END = WW'(SYNC_STAGE + 1);

    logic [WW-1:0] warm_q, warm_d;
    logic          warm_done;

    assign warm_done = (warm_q == WARM_END);

    always_comb begin
        warm_d = warm_q;
        if (!warm_done) begin
            warm_d = warm_q + WW'(1);
        end
    end

    // Holds off edge detection until the chains and prev regs
    // reflect the real input levels after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_q <= '0;
        end else begin
            warm_q <= warm_d;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        sync_pulse_chan #(
            .SYNC_STAGE (SYNC_STAGE),
            .CNT_W      (CNT_W),
            .MODE       (EDGE_MODE[2*i +: 2])
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .sig_async_i (sig_async[i]),
            .warm_done_i (warm_done),
            .clr_i       (clr),
            .ack_i       (ack[i]),
            .pulse_o     (pulse_out[i]),
            .pend_o      (pend[i]),
            .overrun_o   (overrun[i]),
            .cnt_o       (evt_cnt[CNT_W*i +: CNT_W])
        );
    end

endmodule

// File: tb/tb_sync_pulse_multi_capture.sv
// Randomized + directed bench for sync_pulse_multi_capture with a
// behavioural sample-history model of the synchronizer.
module tb_sync_pulse_multi_capture;

    localparam int CH = 4;
    localparam int S  = 2;
    localparam int W  = 2;
    localparam logic [2*CH-1:0] MODES = 8'b11_10_01_00;

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] sig;
    logic [CH-1:0] ack;
    logic          clr;
    logic [CH-1:0] pulse_out;
    logic [CH-1:0] pend;
    logic [CH-1:0] overrun;
    logic [CH*W-1:0] evt_cnt;

    int errs;
    int checks;

    logic [CH-1:0] hq[$];
    int            n_pe;
    logic [CH-1:0] m_pulse;
    logic [CH-1:0] m_pend;
    logic [CH-1:0] m_ovr;
    int            m_cnt[CH];
    int            pc[CH];

    sync_pulse_multi_capture #(
        .CH         (CH),
        .SYNC_STAGE (S),
        .CNT_W      (W),
        .EDGE_MODE  (MODES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_async (sig),
        .ack       (ack),
        .clr       (clr),
        .pulse_out (pulse_out),
        .pend      (pend),
        .overrun   (overrun),
        .evt_cnt   (evt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hq.delete();
        for (int j = 0; j <= S; j++) hq.push_back('0);
        n_pe    = 0;
        m_pulse = '0;
        m_pend  = '0;
        m_ovr   = '0;
        for (int i = 0; i < CH; i++) m_cnt[i] = 0;
    endtask

    // Event at posedge t: edge between the samples taken at t-S-1
    // and t-S, only once S+1 posedges have passed since release.
    task automatic model_step(input logic [CH-1:0] s,
                              input logic [CH-1:0] a, input logic c);
        logic [CH-1:0] e;
        logic cur, prv;
        int md;
        n_pe++;
        for (int i = 0; i < CH; i++) begin
            cur = hq[S-1][i];
            prv = hq[S][i];
            md  = int'(MODES[2*i +: 2]);
            e[i] = 1'b0;
            if (n_pe >= S + 2) begin
                if (md == 0) e[i] = (cur != prv);
                if (md == 1) e[i] = cur && !prv;
                if (md == 2) e[i] = !cur && prv;
            end
        end
        hq.push_front(s);
        void'(hq.pop_back());
        for (int i = 0; i < CH; i++) begin
            if (c) m_ovr[i] = 1'b0;
            else if (e[i] && m_pend[i] && !a[i]) m_ovr[i] = 1'b1;
            if (c) m_cnt[i] = e[i] ? 1 : 0;
            else if (e[i] && m_cnt[i] < (1 << W) - 1) m_cnt[i]++;
            if (e[i]) m_pend[i] = 1'b1;
            else if (a[i]) m_pend[i] = 1'b0;
        end
        m_pulse = e;
    endtask

    task automatic compare();
        logic [CH*W-1:0] ec;
        for (int i = 0; i < CH; i++) ec[W*i +: W] = W'(m_cnt[i]);
        chk("pulse_out", 8'(pulse_out), 8'(m_pulse));
        chk("pend", 8'(pend), 8'(m_pend));
        chk("overrun", 8'(overrun), 8'(m_ovr));
        chk("evt_cnt", 8'(evt_cnt), 8'(ec));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_step(sig, ack, clr);
        @(negedge clk);
        compare();
        for (int i = 0; i < CH; i++) if (pulse_out[i]) pc[i]++;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        rst_n  = 1'b0;
        sig    = 4'b1111;
        ack    = '0;
        clr    = 1'b0;
        model_reset();
        steps(3);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("warm_pulse", 8'(pulse_out), 8'h00);
            chk("warm_pend", 8'(pend), 8'h00);
        end
        chk("warm_cnt", evt_cnt, 8'h00);

        // ch0 any-edge toggles, pulse lands S steps after sampling
        for (int t = 0; t < 3; t++) begin
            sig[0] = ~sig[0];
            for (int j = 0; j < 4; j++) begin
                step();
                chk("lat0", 8'(pulse_out[0]), 8'(j == S));
            end
        end
        chk("tog_cnt0", 8'(evt_cnt[W-1:0]), 8'd3);
        chk("tog_pend0", 8'(pend[0]), 8'd1);
        chk("tog_ovr0", 8'(overrun[0]), 8'd1);

        for (int i = 0; i < CH; i++) pc[i] = 0;
        sig[3:1] = 3'b000;
        steps(5);
        sig[3:1] = 3'b111;
        steps(5);
        sig[3:1] = 3'b000;
        steps(5);
        chk("rise_ch1", 8'(pc[1]), 8'd1);
        chk("fall_ch2", 8'(pc[2]), 8'd2);
        chk("off_ch3", 8'(pc[3]), 8'd0);

        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_cnt", evt_cnt, 8'h00);
        chk("clr_ovr", 8'(overrun), 8'h00);
        sig[0] = ~sig[0];
        steps(2);
        ack[0] = 1'b1;
        step();
        ack[0] = 1'b0;
        chk("ea_pulse0", 8'(pulse_out[0]), 8'd1);
        chk("ea_pend0", 8'(pend[0]), 8'd1);
        chk("ea_ovr0", 8'(overrun[0]), 8'd0);
        ack[0] = 1'b1;
        step();
        ack[0] = 1'b0;
        chk("ack_pend0", 8'(pend[0]), 8'd0);

        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int t = 0; t < 5; t++) begin
            sig[0] = ~sig[0];
            steps(3);
        end
        chk("sat_cnt0", 8'(evt_cnt[W-1:0]), 8'd3);
        chk("sat_ovr0", 8'(overrun[0]), 8'd1);
        sig[0] = ~sig[0];
        steps(2);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clrevt_cnt0", 8'(evt_cnt[W-1:0]), 8'd1);
        chk("clrevt_ovr0", 8'(overrun[0]), 8'd0);

        for (int k = 0; k < 200; k++) begin
            sig = sig ^ 4'($urandom & $urandom);
            for (int j = 0; j < 2; j++) begin
                ack = 4'($urandom & $urandom);
                clr = ($urandom_range(0, 15) == 0);
                step();
            end
        end
        ack = '0;
        clr = 1'b0;

        sig[0] = ~sig[0];
        steps(4);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_pulse", 8'(pulse_out), 8'h00);
        chk("rst_pend", 8'(pend), 8'h00);
        chk("rst_ovr", 8'(overrun), 8'h00);
        chk("rst_cnt", evt_cnt, 8'h00);
        sig = 4'($urandom);
        steps(3);
        rst_n = 1'b1;
        steps(6);
        sig[0] = ~sig[0];
        steps(4);
        chk("post_cnt", evt_cnt, 8'h01);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
